// File: rtl/ghost_scheduler_pkg.sv
// Shared constants and types for the ghost movement scheduler.
package ghost_scheduler_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TILE     = 20;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef enum logic [1:0] {
    DIR_W = 2'd0,
    DIR_S = 2'd1,
    DIR_A = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [1:0]     dir;
    logic           hit;
  } mv_rsp_t;

  // Ghosts spawn side by side, one tile apart.
  function automatic logic [X_W-1:0] spawn_x(input int base, input int i);
    return X_W'(base + TILE * i);
  endfunction

endpackage

// File: rtl/ghost_scheduler_tick_gen.sv
// Movement tick divider: one-cycle tick every TICK_DIV enabled clocks.
module tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = enable && wrap && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt_q <= '0;
    else if (clear)   cnt_q <= '0;
    else if (enable)  cnt_q <= wrap ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/ghost_scheduler.sv
// Time-shares one movement unit across NUM_GHOSTS ghosts, one sweep per tick.
module ghost_scheduler
  import ghost_scheduler_pkg::*;
#(
  parameter int NUM_GHOSTS = 4,
  parameter int TICK_DIV   = 2500000,
  parameter int TIMEOUT    = 15,
  parameter int SPAWN_X    = 300,
  parameter int SPAWN_Y    = 220,
  localparam int IDX_W     = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        restart,
  output logic                        mv_req,
  output logic [IDX_W-1:0]            mv_idx,
  output logic [X_W-1:0]              mv_prev_x,
  output logic [Y_W-1:0]              mv_prev_y,
  input  logic                        mv_valid,
  input  logic [X_W-1:0]              mv_x,
  input  logic [Y_W-1:0]              mv_y,
  input  logic [1:0]                  mv_dir,
  input  logic                        mv_hit,
  output logic [NUM_GHOSTS*X_W-1:0]   ghost_x,
  output logic [NUM_GHOSTS*Y_W-1:0]   ghost_y,
  output logic [NUM_GHOSTS*2-1:0]     ghost_dir,
  output logic                        game_over,
  output logic                        frame_done,
  output logic                        overrun,
  output logic                        timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef logic [NUM_GHOSTS-1:0][X_W-1:0] xs_t;

  function automatic xs_t spawn_xs();
    xs_t v;
    for (int i = 0; i < NUM_GHOSTS; i++) v[i] = spawn_x(SPAWN_X, i);
    return v;
  endfunction

  localparam xs_t SPAWN_XS = spawn_xs();

  state_e                             state_q;
  logic [IDX_W-1:0]                   idx_q, nxt_idx;
  logic [TW-1:0]                      wait_q;
  mv_rsp_t                            rsp_q;
  logic [NUM_GHOSTS-1:0][X_W-1:0]     gx_q;
  logic [NUM_GHOSTS-1:0][Y_W-1:0]     gy_q;
  logic [NUM_GHOSTS-1:0][1:0]         gd_q;
  logic                               mv_req_q, frame_done_q;
  logic                               game_over_q, overrun_q, timeout_err_q;
  logic [X_W-1:0]                     prev_x_q;
  logic [Y_W-1:0]                     prev_y_q;
  logic                               tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (restart),
    .tick   (tick)
  );

  assign nxt_idx = idx_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      rsp_q         <= '0;
      gx_q          <= SPAWN_XS;
      gy_q          <= {NUM_GHOSTS{Y_W'(SPAWN_Y)}};
      gd_q          <= '0;
      mv_req_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      game_over_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      prev_x_q      <= SPAWN_XS[0];
      prev_y_q      <= Y_W'(SPAWN_Y);
    end else if (restart) begin
      // Dropping back to IDLE is what discards any result still in flight.
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      rsp_q         <= '0;
      gx_q          <= SPAWN_XS;
      gy_q          <= {NUM_GHOSTS{Y_W'(SPAWN_Y)}};
      gd_q          <= '0;
      mv_req_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      game_over_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      prev_x_q      <= SPAWN_XS[0];
      prev_y_q      <= Y_W'(SPAWN_Y);
    end else begin
      mv_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (tick && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (tick && !game_over_q) begin
            state_q  <= ST_ISSUE;
            idx_q    <= '0;
            mv_req_q <= 1'b1;
            prev_x_q <= gx_q[0];
            prev_y_q <= gy_q[0];
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          wait_q  <= '0;
        end
        ST_WAIT: begin
          // A response landing on the expiry cycle still wins.
          if (mv_valid) begin
            rsp_q   <= '{x: mv_x, y: mv_y, dir: mv_dir, hit: mv_hit};
            state_q <= ST_COMMIT;
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            rsp_q         <= '{x: gx_q[idx_q], y: gy_q[idx_q], dir: gd_q[idx_q], hit: 1'b0};
            timeout_err_q <= 1'b1;
            state_q       <= ST_COMMIT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          gx_q[idx_q] <= rsp_q.x;
          gy_q[idx_q] <= rsp_q.y;
          gd_q[idx_q] <= rsp_q.dir;
          if (rsp_q.hit) game_over_q <= 1'b1;
          if (idx_q == IDX_W'(NUM_GHOSTS - 1)) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            idx_q    <= nxt_idx;
            mv_req_q <= 1'b1;
            prev_x_q <= gx_q[nxt_idx];
            prev_y_q <= gy_q[nxt_idx];
            state_q  <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mv_req      = mv_req_q;
  assign mv_idx      = idx_q;
  assign mv_prev_x   = prev_x_q;
  assign mv_prev_y   = prev_y_q;
  assign ghost_x     = gx_q;
  assign ghost_y     = gy_q;
  assign ghost_dir   = gd_q;
  assign game_over   = game_over_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
